// File: rtl/hilo_muldiv_unit_pkg.sv
// hilo_muldiv_unit_pkg: op encodings, FSM states and shared constants for the HI/LO mul/div engine.
package hilo_muldiv_unit_pkg;
  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;
  localparam logic [63:0] DIV0_QUOT = '1;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;
  function automatic logic is_div(input logic [1:0] op);
    return op == OP_DIV || op == OP_DIVU;
  endfunction
  function automatic logic is_signed(input logic [1:0] op);
    return op == OP_MULT || op == OP_DIV;
  endfunction
endpackage

// File: rtl/hilo_muldiv_unit_muldiv_step.sv
// muldiv_step: one combinational iteration, shift-add multiply or restoring-divide step on {hi,lo}.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   acc_o
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;
  always_comb begin
    sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, b_i} : '0);
    rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
    // a magnitude compare rather than the borrow bit keeps divide-by-zero well defined
    ge     = rem_sh >= {1'b0, b_i};
    diff   = rem_sh[WIDTH-1:0] - b_i;
    acc_o  = is_div_i ? {ge ? diff : rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], ge}
                      : {sum, acc_i[WIDTH-1:1]};
  end
endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative MULT/MULTU/DIV/DIVU producing the {HI,LO} write, one bit per cycle.
// Define DIV_ZERO_FLAG_EN to add the div0 output pulsed with done on divide by zero.
module hilo_muldiv_unit import hilo_muldiv_unit_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   opA,
  input  logic [WIDTH-1:0]   opB,
  input  logic               cancel,
  output logic               busy,
  output logic               done,
  output logic               RegWrite,
  output logic [2*WIDTH-1:0] WriteData
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic               div0
`endif
);
  localparam int CW = $clog2(WIDTH);
  state_e             state_q;
  logic [1:0]         op_q;
  logic [CW-1:0]      cnt_q;
  logic               sa_q, sb_q, busy_q, done_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc_q, wd_q, step_acc, fix_d;
  logic               neg_a, neg_b, b_zero;
  logic [WIDTH-1:0]   mag_a, mag_b, quo, rem;
`ifdef DIV_ZERO_FLAG_EN
  logic               div0_q;
  assign div0 = div0_q;
`endif
  always_comb begin
    neg_a  = is_signed(op) & opA[WIDTH-1];
    neg_b  = is_signed(op) & opB[WIDTH-1];
    mag_a  = neg_a ? -opA : opA;
    mag_b  = neg_b ? -opB : opB;
    b_zero = b_q == '0;
    quo    = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem    = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    // sign flags are only ever set for signed ops, so unsigned results pass straight through
    fix_d  = is_div(op_q) ? {rem, b_zero ? DIV0_QUOT[WIDTH-1:0] : quo}
                          : (sa_q ^ sb_q) ? -acc_q : acc_q;
  end
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div(op_q)),
    .acc_i    (acc_q),
    .b_i      (b_q),
    .acc_o    (step_acc)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      b_q     <= '0;
      acc_q   <= '0;
      wd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      div0_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          // the done pulse cycle still counts as busy, so a start there is ignored
          if (done_q) begin
            done_q <= 1'b0;
            busy_q <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            div0_q <= 1'b0;
`endif
          end else if (start) begin
            op_q    <= op;
            sa_q    <= neg_a;
            sb_q    <= neg_b;
            b_q     <= is_div(op) ? mag_b : mag_a;
            acc_q   <= {{WIDTH{1'b0}}, is_div(op) ? mag_a : mag_b};
            cnt_q   <= CW'(WIDTH - 1);
            busy_q  <= 1'b1;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          if (cancel) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            acc_q   <= step_acc;
            cnt_q   <= cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
            state_q <= cnt_q == '0 ? S_FIX : S_CALC;
          end
        end
        S_FIX: begin
          if (cancel) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            wd_q    <= fix_d;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
          div0_q  <= is_div(op_q) & b_zero;
`endif
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign busy      = busy_q;
  assign done      = done_q;
  assign RegWrite  = done_q;
  assign WriteData = wd_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: randomized and directed checks of hilo_muldiv_unit against a transaction-level model.
module tb_hilo_muldiv_unit;
  logic        clk, rst, start, cancel, busy, done, RegWrite;
  logic [1:0]  op;
  logic [31:0] opA, opB;
  logic [63:0] WriteData;
`ifdef DIV_ZERO_FLAG_EN
  logic        div0;
`endif
  int          tests = 0, fails = 0, cyc = 0, s = 0, n_ops = 0, rw_cnt = 0;
  bit          live = 0, cur_d0 = 0, ed, eb;
  logic [63:0] cur = '0, held = '0;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .opA       (opA),
    .opB       (opB),
    .cancel    (cancel),
    .busy      (busy),
    .done      (done),
    .RegWrite  (RegWrite),
    .WriteData (WriteData)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .div0      (div0)
`endif
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (RegWrite === 1'b1) rw_cnt <= rw_cnt + 1;

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, m;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == 2'd0) r = sa * sb;
    else if (o == 2'd1) r = {32'd0, a} * {32'd0, b};
    else if (b == 32'd0) r = {a, 32'hFFFFFFFF};
    else if (o == 2'd2) begin
      q = sa / sb;
      m = sa % sb;
      r = {m[31:0], q[31:0]};
    end else r = {a % b, a / b};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // start sampled at cycle s: busy spans s..s+34, done/RegWrite at s+34
  always @(negedge clk) begin
    ed = live && cyc == s + 34;
    eb = live && cyc >= s && cyc <= s + 34;
    chk("done", {63'd0, done}, {63'd0, ed});
    chk("regwrite", {63'd0, RegWrite}, {63'd0, ed});
    chk("busy", {63'd0, busy}, {63'd0, eb});
    if (ed) chk("wdata", WriteData, cur);
    else if (!eb) chk("wdata_hold", WriteData, held);
`ifdef DIV_ZERO_FLAG_EN
    chk("div0", {63'd0, div0}, {63'd0, ed && cur_d0});
`endif
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic c);
    @(negedge clk);
    start = 1; op = o; opA = a; opB = b; cancel = c;
    @(posedge clk);
    #1;
    start = 0; cancel = 0;
    s = cyc; cur = model(o, a, b); cur_d0 = o[1] && b == 32'd0; live = 1;
  endtask

  task automatic finish_op();
    wait_cyc(s + 35);
    held = cur; live = 0; n_ops++;
  endtask

  task automatic glitch(input int k);
    wait_cyc(s + k);
    @(negedge clk);
    start = 1; op = 2'($urandom_range(0, 3)); opA = $urandom; opB = $urandom;
    @(posedge clk);
    #1;
    start = 0;
  endtask

  function automatic logic [31:0] pick();
    int k;
    k = $urandom_range(0, 7);
    return k == 0 ? 32'd0 : k == 1 ? 32'd1 : k == 2 ? 32'hFFFFFFFF : k == 3 ? 32'h80000000 : 32'($urandom);
  endfunction

  initial begin
    rst = 0; start = 0; cancel = 0; op = 0; opA = 0; opB = 0;
    repeat (3) @(negedge clk);
    chk("reset_wd", WriteData, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    #2 rst = 1;
    chk("pin_multu", model(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF), 64'hFFFFFFFE_00000001);
    chk("pin_mult", model(2'd0, 32'hFFFFFFFD, 32'd7), 64'hFFFFFFFF_FFFFFFEB);
    chk("pin_div", model(2'd2, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
    chk("pin_div0", model(2'd3, 32'd100, 32'd0), 64'h00000064_FFFFFFFF);
    chk("pin_divovf", model(2'd2, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);
    chk("pin_sdiv0", model(2'd2, 32'hFFFFFFF9, 32'd0), 64'hFFFFFFF9_FFFFFFFF);
    issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0); finish_op();
    chk("lit_multu", WriteData, 64'hFFFFFFFE_00000001);
    issue(2'd0, 32'hFFFFFFFD, 32'd7, 0); finish_op();
    chk("lit_mult", WriteData, 64'hFFFFFFFF_FFFFFFEB);
    issue(2'd2, 32'hFFFFFFF9, 32'd2, 0); finish_op();
    chk("lit_div", WriteData, 64'hFFFFFFFF_FFFFFFFD);
    issue(2'd3, 32'd100, 32'd0, 0); finish_op();
    chk("lit_divu0", WriteData, 64'h00000064_FFFFFFFF);
    issue(2'd2, 32'h80000000, 32'hFFFFFFFF, 0); finish_op();
    chk("lit_divovf", WriteData, 64'h00000000_80000000);
    issue(2'd2, 32'hFFFFFFF9, 32'd0, 0); finish_op();
    chk("lit_sdiv0", WriteData, 64'hFFFFFFF9_FFFFFFFF);
    issue(2'd3, 32'd1000, 32'd7, 0); glitch(5); glitch(33); finish_op();
    chk("lit_busy_start", WriteData, {32'd6, 32'd142});
    issue(2'd0, 32'd5, 32'd6, 1); finish_op();
    chk("lit_start_wins", WriteData, 64'd30);
    issue(2'd1, 32'd12345, 32'd678, 0);
    wait_cyc(s + 10);
    @(negedge clk);
    cancel = 1;
    @(posedge clk);
    #1;
    cancel = 0; live = 0;
    repeat (40) @(posedge clk);
    #1;
    chk("cancel_hold", WriteData, 64'd30);
    issue(2'd2, 32'd55, 32'd3, 0);
    wait_cyc(s + 20);
    @(negedge clk);
    #2 rst = 0; live = 0; held = 0;
    #1;
    chk("rst_wd", WriteData, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1;
    issue(2'd3, 32'd10, 32'd3, 0); finish_op();
    chk("lit_divu_after", WriteData, {32'd1, 32'd3});
    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) glitch($urandom_range(1, 30));
      finish_op();
    end
    repeat (2) @(posedge clk);
    #1;
    chk("regwrite_count", 64'(rw_cnt), 64'(n_ops));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Iterative multiply/divide engine that produces the 64-bit {HI,LO} write for the HI/LO register pair.
- Accepts one MULT/MULTU/DIV/DIVU per start, iterates one bit per cycle, then issues a single-cycle write strobe with the 2*WIDTH result.
- Sits between the ID/EX operand latches and the HI/LO storage.
- The pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH, iteration count is WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  0=MULT (signed), 1=MULTU, 2=DIV (signed), 3=DIVU.
- opA  input  WIDTH  multiplicand / dividend; sampled with start.
- opB  input  WIDTH  multiplier / divisor; sampled with start.
- cancel  input  1  abort the in-flight operation; no write issued.
- busy  output  1  high from the cycle after start is accepted until done drops.
- done  output  1  one-cycle completion pulse.
- RegWrite  output  1  HI/LO write strobe; identical timing to done.
- WriteData  output  2*WIDTH  {HI,LO} result; held stable from done until the next accepted start.
- div0  output  1  present only with DIV_ZERO_FLAG_EN; see Optional Feature.

Behaviour:
- Reset (rst=0, async): FSM to IDLE; busy, done, RegWrite, WriteData, counter and all internal registers clear to 0.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE + start=1: latch op and the operand magnitudes (|opA|, |opB| for signed ops), record sign bits, load counter=WIDTH-1, go to CALC.
- IDLE + start=0: stay in IDLE.
- CALC: one iteration per cycle. Multiply is shift-add on a 2*WIDTH accumulator. Divide is restoring: shift the remainder left, trial-subtract the divisor, set the quotient bit.
  - counter==0: go to FIX.
  - otherwise decrement counter.
- FIX (1 cycle): apply signs and write WriteData.
  - Signed MULT: negate the product when the operand signs differ.
  - Signed DIV: quotient negative when signs differ; remainder takes the dividend's sign (truncation toward zero).
  - Go to DONE.
- DONE (1 cycle): done=1, RegWrite=1, busy=1; next state IDLE.
- Latency: if start is sampled at edge E0, done/RegWrite are high during the cycle after edge E(WIDTH+2), i.e. E34 for WIDTH=32.
- The earliest back-to-back start is the cycle after DONE.
- Divide layout: HI=remainder, LO=quotient. Multiply layout: HI=upper product, LO=lower product.
- Arithmetic is modulo 2^(2*WIDTH); no overflow flag.
- Divide by zero: quotient = all ones, remainder = dividend (opA as given). Full latency still applies.
- Signed DIV of -2^(WIDTH-1) by -1: quotient = 0x80000000, remainder = 0. This is the natural wrap result; no exception.
- start while busy: ignored, no queueing; operands are not resampled.
- cancel: in CALC or FIX, go to IDLE next edge. No done, no RegWrite, WriteData unchanged. cancel in IDLE or DONE has no effect.
- cancel and start in the same IDLE cycle: start wins.
- Reset mid-operation: immediate abort, outputs to reset values, no write.

Optional Feature:
- Macro DIV_ZERO_FLAG_EN.
- Defined: div0 output exists. div0=1 together with done when the op is DIV/DIVU and opB==0; otherwise 0. Reset value 0.
- Undefined: no div0 port and no comparator; divide-by-zero results are unchanged.

Decomposition:
- Shared package holds:
  - op encodings OP_MULT=2'd0, OP_MULTU=2'd1, OP_DIV=2'd2, OP_DIVU=2'd3;
  - FSM state encoding;
  - constant DIV0_QUOT (all ones).
- One natural sub-module: muldiv_step. It is the combinational one-iteration datapath (add-shift or subtract-shift selected by op); the FSM/counter wrapper instantiates it once.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> done after 34 edges, WriteData=0xFFFFFFFE_00000001, RegWrite one cycle.
- MULT -3*7 -> WriteData=0xFFFFFFFF_FFFFFFEB; then DIV -7/2 -> HI=0xFFFFFFFF (-1), LO=0xFFFFFFFD (-3).
- DIVU 100/0 -> HI=100, LO=0xFFFFFFFF; with DIV_ZERO_FLAG_EN, div0=1 exactly with done.
- DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- start pulsed during busy with different operands -> ignored; result matches the first operands; only one RegWrite pulse.
- cancel at iteration 10, and separately rst low at iteration 20 -> no RegWrite. After cancel, WriteData keeps its prior value. After reset, all outputs 0. A new DIVU 10/3 afterwards returns HI=1, LO=3.
